// File: rtl/async_fifo_pkg.sv
// Shared async FIFO types and Gray/binary conversions. Functions work on a wide vector;
// callers zero-extend their pointer in and size-cast the result back.
package async_fifo_pkg;

  localparam int unsigned DefaultAddrWidth = 4;
  localparam int unsigned MaxPtrWidth      = 32;

  typedef logic [DefaultAddrWidth:0] ptr_t;
  typedef logic [MaxPtrWidth-1:0]    wide_ptr_t;

  function automatic wide_ptr_t bin2gray(input wide_ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic wide_ptr_t gray2bin(input wide_ptr_t gray);
    wide_ptr_t bin;
    bin[MaxPtrWidth-1] = gray[MaxPtrWidth-1];
    for (int i = MaxPtrWidth - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-stage flop chain for moving a Gray pointer into another clock domain.
module ptr_sync #(
  parameter int unsigned Stages = 2,
  parameter int unsigned Width  = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync_q [Stages];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < Stages; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < Stages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Async FIFO write-side pointer, Gray publish and registered full flag (write clock domain).
// Define FIFO_ALMOST_FULL_EN to add the registered almost_full_o output.
module fifo_wptr_full
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DefaultAddrWidth,
  parameter int unsigned SYNC_STAGES = 2
`ifdef FIFO_ALMOST_FULL_EN
  ,
  parameter int unsigned AFULL_LEVEL = (1 << ADDR_WIDTH) - 2
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  winc_i,
  input  logic [ADDR_WIDTH:0]   rgray_i,
  output logic                  wen_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [ADDR_WIDTH:0]   wgray_o,
  output logic                  full_o
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic                  almost_full_o
`endif
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH:0] wbin_q, wbin_d;
  logic [ADDR_WIDTH:0] wgray_q, wgray_d;
  logic [ADDR_WIDTH:0] rq_sync, full_cmp;
  logic                full_q, full_d;
  logic                winc_ok;

  ptr_sync #(
    .Stages(SYNC_STAGES),
    .Width (PtrW)
  ) u_rgray_sync (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .d_i    (rgray_i),
    .q_o    (rq_sync)
  );

  assign winc_ok = winc_i & ~full_q;

  always_comb begin
    wbin_d   = wbin_q + PtrW'(winc_ok);
    wgray_d  = PtrW'(bin2gray(wide_ptr_t'(wbin_d)));
    // Full when write is one lap ahead: top two Gray bits inverted, rest equal.
    full_cmp = rq_sync ^ {2'b11, {(ADDR_WIDTH - 1){1'b0}}};
    full_d   = (wgray_d == full_cmp);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
    end
  end

  assign wen_o   = winc_ok;
  assign waddr_o = wbin_q[ADDR_WIDTH-1:0];
  assign wgray_o = wgray_q;
  assign full_o  = full_q;

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [ADDR_WIDTH:0] AfullLevel = PtrW'(AFULL_LEVEL);

  logic [ADDR_WIDTH:0] rbin_sync, level_d;
  logic                afull_q, afull_d;

  always_comb begin
    rbin_sync = PtrW'(gray2bin(wide_ptr_t'(rq_sync)));
    level_d   = wbin_d - rbin_sync;
    afull_d   = (level_d >= AfullLevel);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= afull_d;
    end
  end

  assign almost_full_o = afull_q;
`endif

endmodule
